// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: pipeline request/response and memory bus signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the pipeline/bus environment.
interface lsu_mem_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned NB = XLEN / 8;

    // pipeline request side
    logic            req_valid_i;
    logic            req_ready_o;
    logic            ld_i;
    logic            st_i;
    logic [6:0]      ld_fun_i;
    logic [3:0]      st_fun_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] wdata_i;

    // pipeline response side
    logic            resp_valid_o;
    logic [XLEN-1:0] rdata_o;
    logic            misalign_o;
    logic            fault_o;

    // memory bus side
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [NB-1:0]   mem_wmask_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_err_i;

    modport slave (
        input  req_valid_i, ld_i, st_i, ld_fun_i, st_fun_i, addr_i, wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output req_ready_o, resp_valid_o, rdata_o, misalign_o, fault_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );

    modport master (
        output req_valid_i, ld_i, st_i, ld_fun_i, st_fun_i, addr_i, wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  req_ready_o, resp_valid_o, rdata_o, misalign_o, fault_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store unit issuing one aligned access on a
// request/grant/response bus and returning extended load data as a one-cycle response.
// Optional: define LSU_TIMEOUT_EN to abort REQ/WAIT with a fault after TIMEOUT cycles;
// without it the unit waits indefinitely for grant and response.
module lsu_mem_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    // Reject parameter values the datapath is not built for.
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("lsu_mem_ctrl: XLEN must be 32 or 64");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("lsu_mem_ctrl: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [OFFW-1:0] off_q;
    logic            st_q;
    logic [6:0]      ld_fun_q;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    logic [OFFW-1:0] off_c;
    logic [2:0]      off3_c;
    logic            sz_b_c;
    logic            sz_h_c;
    logic            sz_w_c;
    logic            sz_d_c;
    logic            illegal_c;
    logic            misalign_c;
    logic [NB-1:0]   lane_sz_c;
    logic [NB-1:0]   lane_c;
    logic [XLEN-1:0] dmask_c;
    logic [XLEN-1:0] wpos_c;
    logic [XLEN-1:0] rshift_c;
    logic [XLEN-1:0] rext_c;

    assign off_c  = bus.addr_i[OFFW-1:0];
    assign off3_c = 3'(off_c);

    // Decode the incoming request: access size, legality and alignment.
    always_comb begin
        sz_b_c = bus.ld_i ? (bus.ld_fun_i[0] | bus.ld_fun_i[3]) : bus.st_fun_i[0];
        sz_h_c = bus.ld_i ? (bus.ld_fun_i[1] | bus.ld_fun_i[4]) : bus.st_fun_i[1];
        sz_w_c = bus.ld_i ? (bus.ld_fun_i[2] | bus.ld_fun_i[6]) : bus.st_fun_i[2];
        sz_d_c = bus.ld_i ? bus.ld_fun_i[5] : bus.st_fun_i[3];

        illegal_c = (bus.ld_i & bus.st_i)
                  | (bus.ld_i ? !$onehot(bus.ld_fun_i) : !$onehot(bus.st_fun_i))
                  | ((XLEN == 32)
                     && (bus.ld_i ? (bus.ld_fun_i[5] | bus.ld_fun_i[6]) : bus.st_fun_i[3]));

        misalign_c = (sz_h_c & off3_c[0])
                   | (sz_w_c & (|off3_c[1:0]))
                   | (sz_d_c & (|off3_c));
    end

    // Size-dependent byte-lane and data masks for stores.
    always_comb begin
        lane_sz_c = '0;
        dmask_c   = '0;
        if (sz_b_c) begin
            lane_sz_c = NB'(1);
            dmask_c   = XLEN'(8'hFF);
        end else if (sz_h_c) begin
            lane_sz_c = NB'(3);
            dmask_c   = XLEN'(16'hFFFF);
        end else if (sz_w_c) begin
            lane_sz_c = NB'(15);
            dmask_c   = XLEN'(32'hFFFF_FFFF);
        end else if (sz_d_c) begin
            lane_sz_c = '1;
            dmask_c   = '1;
        end
    end

    assign lane_c = lane_sz_c << off_c;
    assign wpos_c = (bus.wdata_i & dmask_c) << {off_c, 3'b000};

    // Right-align returned bus data and extend it according to the latched load function.
    assign rshift_c = bus.mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        rext_c = '0;
        if (ld_fun_q[0]) begin
            rext_c = XLEN'($signed(rshift_c[7:0]));
        end else if (ld_fun_q[1]) begin
            rext_c = XLEN'($signed(rshift_c[15:0]));
        end else if (ld_fun_q[2]) begin
            rext_c = XLEN'($signed(rshift_c[31:0]));
        end else if (ld_fun_q[3]) begin
            rext_c = XLEN'(rshift_c[7:0]);
        end else if (ld_fun_q[4]) begin
            rext_c = XLEN'(rshift_c[15:0]);
        end else if (ld_fun_q[5]) begin
            rext_c = rshift_c;
        end else if (ld_fun_q[6]) begin
            rext_c = XLEN'(rshift_c[31:0]);
        end
    end

    // Control FSM with registered pipeline and bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            off_q            <= '0;
            st_q             <= 1'b0;
            ld_fun_q         <= '0;
            bus.req_ready_o  <= 1'b1;
            bus.resp_valid_o <= 1'b0;
            bus.rdata_o      <= '0;
            bus.misalign_o   <= 1'b0;
            bus.fault_o      <= 1'b0;
            bus.mem_req_o    <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_wdata_o  <= '0;
            bus.mem_wmask_o  <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
        end else begin
            bus.resp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid_i && (bus.ld_i || bus.st_i)) begin
                        bus.req_ready_o <= 1'b0;
                        bus.misalign_o  <= 1'b0;
                        bus.fault_o     <= 1'b0;
                        off_q           <= off_c;
                        st_q            <= bus.st_i;
                        ld_fun_q        <= bus.ld_i ? bus.ld_fun_i : 7'b0;
                        if (illegal_c) begin
                            bus.fault_o      <= 1'b1;
                            bus.rdata_o      <= '0;
                            bus.resp_valid_o <= 1'b1;
                            state            <= S_RESP;
                        end else if (misalign_c) begin
                            bus.misalign_o   <= 1'b1;
                            bus.rdata_o      <= '0;
                            bus.resp_valid_o <= 1'b1;
                            state            <= S_RESP;
                        end else begin
                            bus.mem_req_o   <= 1'b1;
                            bus.mem_we_o    <= bus.st_i;
                            bus.mem_addr_o  <= {bus.addr_i[XLEN-1:OFFW], OFFW'(0)};
                            bus.mem_wdata_o <= bus.st_i ? wpos_c : '0;
                            bus.mem_wmask_o <= bus.st_i ? lane_c : '1;
                            state           <= S_REQ;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt         <= '0;
`endif
                        end
                    end
                end

                S_REQ: begin
                    if (bus.mem_gnt_i) begin
                        bus.mem_req_o <= 1'b0;
                        state         <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt       <= '0;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.mem_req_o    <= 1'b0;
                        bus.fault_o      <= 1'b1;
                        bus.rdata_o      <= '0;
                        bus.resp_valid_o <= 1'b1;
                        state            <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end

                S_WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        bus.fault_o      <= bus.mem_err_i;
                        bus.rdata_o      <= (bus.mem_err_i || st_q) ? '0 : rext_c;
                        bus.resp_valid_o <= 1'b1;
                        state            <= S_RESP;
`ifdef LSU_TIMEOUT_EN
                    end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.fault_o      <= 1'b1;
                        bus.rdata_o      <= '0;
                        bus.resp_valid_o <= 1'b1;
                        state            <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
                    end
                end

                S_RESP: begin
                    bus.req_ready_o <= 1'b1;
                    state           <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: drives an XLEN=32 and an XLEN=64 load/store unit from one shared
// stimulus set and checks them against a byte-level reference model.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel64;
    logic        req_valid, ld, st, gnt, rvalid, merr;
    logic [6:0]  lf;
    logic [3:0]  sf;
    logic [63:0] addr, wdata, mrdata;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_mem_ctrl_if #(.XLEN(32)) b32 ();
    lsu_mem_ctrl_if #(.XLEN(64)) b64 ();

    lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(4)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    lsu_mem_ctrl #(.XLEN(64), .TIMEOUT(4)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

    assign b32.req_valid_i  = req_valid & ~sel64;
    assign b32.ld_i         = ld;
    assign b32.st_i         = st;
    assign b32.ld_fun_i     = lf;
    assign b32.st_fun_i     = sf;
    assign b32.addr_i       = addr[31:0];
    assign b32.wdata_i      = wdata[31:0];
    assign b32.mem_gnt_i    = gnt;
    assign b32.mem_rvalid_i = rvalid;
    assign b32.mem_rdata_i  = mrdata[31:0];
    assign b32.mem_err_i    = merr;

    assign b64.req_valid_i  = req_valid & sel64;
    assign b64.ld_i         = ld;
    assign b64.st_i         = st;
    assign b64.ld_fun_i     = lf;
    assign b64.st_fun_i     = sf;
    assign b64.addr_i       = addr;
    assign b64.wdata_i      = wdata;
    assign b64.mem_gnt_i    = gnt;
    assign b64.mem_rvalid_i = rvalid;
    assign b64.mem_rdata_i  = mrdata;
    assign b64.mem_err_i    = merr;

    logic        o_ready, o_resp, o_mis, o_fault, o_mreq, o_we;
    logic [63:0] o_rdata, o_maddr, o_mwdata;
    logic [7:0]  o_mmask;

    assign o_ready  = sel64 ? b64.req_ready_o  : b32.req_ready_o;
    assign o_resp   = sel64 ? b64.resp_valid_o : b32.resp_valid_o;
    assign o_mis    = sel64 ? b64.misalign_o   : b32.misalign_o;
    assign o_fault  = sel64 ? b64.fault_o      : b32.fault_o;
    assign o_mreq   = sel64 ? b64.mem_req_o    : b32.mem_req_o;
    assign o_we     = sel64 ? b64.mem_we_o     : b32.mem_we_o;
    assign o_rdata  = sel64 ? b64.rdata_o      : 64'(b32.rdata_o);
    assign o_maddr  = sel64 ? b64.mem_addr_o   : 64'(b32.mem_addr_o);
    assign o_mwdata = sel64 ? b64.mem_wdata_o  : 64'(b32.mem_wdata_o);
    assign o_mmask  = sel64 ? b64.mem_wmask_o  : 8'(b32.mem_wmask_o);

    typedef struct {
        bit          ld, st, err, stray;
        logic [6:0]  lf;
        logic [3:0]  sf;
        logic [63:0] addr, wdata, bdata;
        int          gd, rd;
    } txn_t;

    typedef struct {
        bit          done, bus, unstable, we, mis, fault;
        bit          ready_busy, flags_busy, pulse_after, ready_after;
        int          lat, req_cycles;
        logic [63:0] maddr, mwdata, rdata, rdata_busy, rdata_after;
        logic [7:0]  mmask;
    } obs_t;

    typedef struct {
        bit          bus, mis, fault, we;
        logic [63:0] maddr, mwdata, rdata;
        logic [7:0]  mmask;
    } exp_t;

    // Reference: what a request should do, derived from access size in bytes and byte offsets.
    function automatic exp_t model(input int xlen, input txn_t t);
        exp_t        e;
        int          nb, size, off;
        bit          sgn, wide_only;
        logic [63:0] v;
        e = '{default: '0};
        nb = xlen / 8; size = 0; sgn = 0; wide_only = 0;
        if (t.ld) begin
            case (t.lf)
                7'b0000001: begin size = 1; sgn = 1; end
                7'b0000010: begin size = 2; sgn = 1; end
                7'b0000100: begin size = 4; sgn = 1; end
                7'b0001000: size = 1;
                7'b0010000: size = 2;
                7'b0100000: begin size = 8; wide_only = 1; end
                7'b1000000: begin size = 4; wide_only = 1; end
                default:    size = 0;
            endcase
        end else begin
            case (t.sf)
                4'b0001: size = 1;
                4'b0010: size = 2;
                4'b0100: size = 4;
                4'b1000: begin size = 8; wide_only = 1; end
                default: size = 0;
            endcase
        end
        if ((t.ld && t.st) || size == 0 || (wide_only && xlen == 32)) begin
            e.fault = 1;
            return e;
        end
        off = int'(t.addr % 64'(nb));
        if ((off % size) != 0) begin
            e.mis = 1;
            return e;
        end
        e.bus   = 1;
        e.we    = t.st;
        e.maddr = t.addr - 64'(off);
        if (t.st) begin
            for (int b = 0; b < size; b++) begin
                e.mwdata[8*(off+b) +: 8] = t.wdata[8*b +: 8];
                e.mmask[off+b] = 1'b1;
            end
        end else begin
            for (int b = 0; b < nb; b++) e.mmask[b] = 1'b1;
            v = '0;
            for (int b = 0; b < size; b++) v[8*b +: 8] = t.bdata[8*(off+b) +: 8];
            if (sgn && v[8*size-1]) for (int b = size; b < 8; b++) v[8*b +: 8] = 8'hFF;
            if (xlen == 32) v[63:32] = '0;
            e.rdata = t.err ? 64'd0 : v;
        end
        e.fault = t.err;
        return e;
    endfunction

    // Drive one request through the selected unit, acting as the memory; records what it saw.
    task automatic do_txn(input txn_t t, output obs_t o);
        int gcnt, wcnt;
        o = '{default: '0};
        gcnt = 0; wcnt = 0;
        @(negedge clk);
        req_valid = 1; ld = t.ld; st = t.st; lf = t.lf; sf = t.sf;
        addr = t.addr; wdata = t.wdata;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            req_valid = 0; gnt = 0; rvalid = 0; merr = 0;
            mrdata = {$urandom, $urandom};
            if (c == 1) begin
                o.ready_busy = o_ready;
                o.flags_busy = o_mis | o_fault;
                o.rdata_busy = o_rdata;
            end
            if (o_resp) begin
                o.done = 1; o.lat = c; o.rdata = o_rdata; o.mis = o_mis; o.fault = o_fault;
                break;
            end
            if (o_mreq) begin
                if (!o.bus) begin
                    o.bus = 1; o.we = o_we; o.maddr = o_maddr; o.mwdata = o_mwdata; o.mmask = o_mmask;
                end else if (o_we !== o.we || o_maddr !== o.maddr || o_mwdata !== o.mwdata
                             || o_mmask !== o.mmask) begin
                    o.unstable = 1;
                end
                o.req_cycles++;
                if (gcnt == t.gd) gnt = 1;
                gcnt++;
                if (t.stray) begin
                    rvalid = 1; merr = 1'($urandom);
                end
            end else if (o.bus) begin
                if (wcnt == t.rd) begin
                    rvalid = 1; mrdata = t.bdata; merr = t.err;
                end
                wcnt++;
            end
        end
        @(negedge clk);
        o.pulse_after = o_resp;
        o.ready_after = o_ready;
        o.rdata_after = o_rdata;
    endtask

    function automatic txn_t mk(input bit l, input bit s, input logic [6:0] f7, input logic [3:0] f4,
                                input logic [63:0] a, input logic [63:0] w, input logic [63:0] bd,
                                input bit e, input int gd, input int rd);
        txn_t t;
        t.ld = l; t.st = s; t.lf = f7; t.sf = f4; t.addr = a; t.wdata = w; t.bdata = bd;
        t.err = e; t.gd = gd; t.rd = rd; t.stray = 0;
        return t;
    endfunction

    task automatic test_reset();
        obs_t o;
        o = '{default: '0};
        for (int s = 0; s < 2; s++) begin
            sel64 = 1'(s);
            #1;
            n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready xlen%0d got %b want 1", 32*(s+1), o_ready); end
            n_cmp++; if ({o_resp, o_mis, o_fault, o_mreq, o_we} !== 5'b0) begin n_fail++; $display("FAIL reset_flags xlen%0d got %b want 00000", 32*(s+1), {o_resp, o_mis, o_fault, o_mreq, o_we}); end
            n_cmp++; if ({o_rdata, o_maddr, o_mwdata, o_mmask} !== '0) begin n_fail++; $display("FAIL reset_data xlen%0d rdata %h maddr %h mwdata %h mmask %h want 0", 32*(s+1), o_rdata, o_maddr, o_mwdata, o_mmask); end
        end
        sel64 = 0;
    endtask

    task automatic test_directed32();
        obs_t o;
        sel64 = 0;
        do_txn(mk(1, 0, 7'b0000001, 4'b0, 64'h8000_0003, 64'h0, 64'h80FF_1234, 0, 0, 0), o);
        n_cmp++; if (o.rdata !== 64'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata got %h want ffffff80", o.rdata); end
        n_cmp++; if (o.lat !== 3) begin n_fail++; $display("FAIL lb_latency got %0d want 3", o.lat); end
        n_cmp++; if (o.fault !== 1'b0 || o.maddr !== 64'h8000_0000) begin n_fail++; $display("FAIL lb_bus fault %b maddr %h want 0 80000000", o.fault, o.maddr); end

        do_txn(mk(0, 1, 7'b0, 4'b0010, 64'h1002, 64'hDEAD_BEEF, 64'h0, 0, 0, 0), o);
        n_cmp++; if (o.maddr !== 64'h1000 || o.mwdata !== 64'hBEEF_0000) begin n_fail++; $display("FAIL sh_addr_data got %h %h want 1000 beef0000", o.maddr, o.mwdata); end
        n_cmp++; if (o.mmask !== 8'b1100 || o.we !== 1'b1) begin n_fail++; $display("FAIL sh_mask_we got %b %b want 1100 1", o.mmask, o.we); end
        n_cmp++; if (o.rdata !== 64'h0 || !o.done) begin n_fail++; $display("FAIL sh_resp got %h done %b want 0 1", o.rdata, o.done); end

        do_txn(mk(1, 0, 7'b0000100, 4'b0, 64'h1001, 64'h0, 64'h0, 0, 0, 0), o);
        n_cmp++; if (o.lat !== 1 || o.mis !== 1'b1 || o.bus !== 1'b0) begin n_fail++; $display("FAIL lw_misalign lat %0d mis %b bus %b want 1 1 0", o.lat, o.mis, o.bus); end

        do_txn(mk(1, 0, 7'b0100000, 4'b0, 64'h1000, 64'h0, 64'h0, 0, 0, 0), o);
        n_cmp++; if (o.lat !== 1 || o.fault !== 1'b1 || o.bus !== 1'b0) begin n_fail++; $display("FAIL ld_on_rv32 lat %0d fault %b bus %b want 1 1 0", o.lat, o.fault, o.bus); end

        do_txn(mk(1, 0, 7'b0010000, 4'b0, 64'h2002, 64'h0, 64'h1234_5678, 1, 0, 1), o);
        n_cmp++; if (o.fault !== 1'b1 || o.rdata !== 64'h0) begin n_fail++; $display("FAIL lhu_bus_err fault %b rdata %h want 1 0", o.fault, o.rdata); end
    endtask

    task automatic test_xlen64();
        obs_t o;
        sel64 = 1;
        do_txn(mk(1, 0, 7'b1000000, 4'b0, 64'h10, 64'h0, 64'hFFFF_FFFF_8765_4321, 0, 5, 0), o);
        n_cmp++; if (o.req_cycles !== 6 || o.unstable) begin n_fail++; $display("FAIL lwu_grant_hold req_cycles %0d unstable %b want 6 0", o.req_cycles, o.unstable); end
        n_cmp++; if (o.rdata !== 64'h0000_0000_8765_4321 || o.lat !== 8) begin n_fail++; $display("FAIL lwu_rdata got %h lat %0d want 87654321 8", o.rdata, o.lat); end
        do_txn(mk(0, 1, 7'b0, 4'b1000, 64'h28, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0), o);
        n_cmp++; if (o.mmask !== 8'hFF || o.mwdata !== 64'h0123_4567_89AB_CDEF || o.maddr !== 64'h28) begin n_fail++; $display("FAIL sd_bus mask %h data %h addr %h want ff 0123456789abcdef 28", o.mmask, o.mwdata, o.maddr); end
        sel64 = 0;
    endtask

    task automatic test_ignored_req();
        bit seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1; ld = 0; st = 0; lf = 7'b0000100; sf = 4'b0100; addr = 64'h100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (!o_ready || o_mreq || o_resp) seen = 1;
        end
        req_valid = 0;
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ignored_req reacted %b want 0", seen); end
    endtask

    task automatic test_timeout();
        obs_t o;
        sel64 = 0;
`ifdef LSU_TIMEOUT_EN
        do_txn(mk(1, 0, 7'b0000100, 4'b0, 64'h40, 64'h0, 64'h0, 0, 1000, 0), o);
        n_cmp++; if (o.req_cycles !== 4 || o.lat !== 5) begin n_fail++; $display("FAIL timeout_req req_cycles %0d lat %0d want 4 5", o.req_cycles, o.lat); end
        n_cmp++; if (o.fault !== 1'b1 || o.rdata !== 64'h0) begin n_fail++; $display("FAIL timeout_resp fault %b rdata %h want 1 0", o.fault, o.rdata); end
`else
        do_txn(mk(1, 0, 7'b0000100, 4'b0, 64'h40, 64'h0, 64'hCAFE_F00D, 0, 10, 2), o);
        n_cmp++; if (o.req_cycles !== 11 || o.lat !== 15) begin n_fail++; $display("FAIL long_wait req_cycles %0d lat %0d want 11 15", o.req_cycles, o.lat); end
        n_cmp++; if (o.fault !== 1'b0 || o.rdata !== 64'hCAFE_F00D) begin n_fail++; $display("FAIL long_wait_resp fault %b rdata %h want 0 cafef00d", o.fault, o.rdata); end
`endif
    endtask

    task automatic test_random();
        txn_t        t;
        obs_t        o;
        exp_t        e;
        int          xl;
        logic [63:0] prev [2];
        prev[0] = 64'hFFFF_FFFF; prev[1] = 64'h0;
        // Seed the 64-bit unit's held rdata with a known response before relying on prev.
        sel64 = 1;
        do_txn(mk(1, 0, 7'b0000001, 4'b0, 64'h0, 64'h0, 64'h0, 0, 0, 0), o);
        prev[1] = 64'h0;
        sel64 = 0;
        do_txn(mk(1, 0, 7'b0000100, 4'b0, 64'h0, 64'h0, 64'hFFFF_FFFF, 0, 0, 0), o);
        for (int i = 0; i < 200; i++) begin
            sel64 = 1'($urandom_range(0, 1));
            xl = sel64 ? 64 : 32;
            t.ld = 1'($urandom_range(0, 1)); t.st = !t.ld;
            t.lf = 7'(1 << $urandom_range(0, 6));
            t.sf = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: t.st = t.ld;
                    1: t.lf = 7'($urandom);
                    default: t.sf = 4'($urandom);
                endcase
                if (!t.ld && !t.st) t.ld = 1;
            end
            t.addr  = {$urandom, $urandom};
            if (xl == 32) t.addr[63:32] = '0;
            if ($urandom_range(0, 1) == 1) t.addr[2:0] = 3'b000;
            t.wdata = {$urandom, $urandom};
            t.bdata = {$urandom, $urandom};
            t.err   = ($urandom_range(0, 9) == 0);
            t.gd    = $urandom_range(0, 3);
            t.rd    = $urandom_range(0, 3);
            t.stray = 1'($urandom_range(0, 1));
            e = model(xl, t);
            do_txn(t, o);
            n_cmp++; if (!o.done || o.lat !== (e.bus ? 3 + t.gd + t.rd : 1)) begin n_fail++; $display("FAIL rnd%0d_latency done %b lat %0d want %0d", i, o.done, o.lat, e.bus ? 3 + t.gd + t.rd : 1); end
            n_cmp++; if (o.bus !== e.bus) begin n_fail++; $display("FAIL rnd%0d_bus_access got %b want %b", i, o.bus, e.bus); end
            n_cmp++; if ({o.mis, o.fault} !== {e.mis, e.fault} || o.rdata !== e.rdata) begin n_fail++; $display("FAIL rnd%0d_resp mis %b fault %b rdata %h want %b %b %h", i, o.mis, o.fault, o.rdata, e.mis, e.fault, e.rdata); end
            n_cmp++; if (o.ready_busy !== 1'b0 || o.pulse_after !== 1'b0 || o.ready_after !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_handshake busy_ready %b pulse_after %b ready_after %b want 0 0 1", i, o.ready_busy, o.pulse_after, o.ready_after); end
            n_cmp++; if (o.rdata_after !== e.rdata) begin n_fail++; $display("FAIL rnd%0d_rdata_hold got %h want %h", i, o.rdata_after, e.rdata); end
            if (e.bus) begin
                n_cmp++; if (o.unstable || o.req_cycles !== t.gd + 1) begin n_fail++; $display("FAIL rnd%0d_req_stable unstable %b req_cycles %0d want 0 %0d", i, o.unstable, o.req_cycles, t.gd + 1); end
                n_cmp++; if (o.we !== e.we || o.maddr !== e.maddr || o.mmask !== e.mmask) begin n_fail++; $display("FAIL rnd%0d_bus_ctrl we %b addr %h mask %h want %b %h %h", i, o.we, o.maddr, o.mmask, e.we, e.maddr, e.mmask); end
                if (t.st) begin
                    n_cmp++; if (o.mwdata !== e.mwdata) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", i, o.mwdata, e.mwdata); end
                end
                n_cmp++; if (o.flags_busy !== 1'b0 || o.rdata_busy !== prev[sel64]) begin n_fail++; $display("FAIL rnd%0d_busy_hold flags %b rdata %h want 0 %h", i, o.flags_busy, o.rdata_busy, prev[sel64]); end
            end
            prev[sel64] = e.rdata;
        end
        sel64 = 0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        sel64 = 0;
        @(negedge clk);
        req_valid = 1; ld = 1; st = 0; lf = 7'b0000001; sf = 4'b0; addr = 64'h2003;
        @(negedge clk);
        req_valid = 0; gnt = 1;
        @(negedge clk);
        gnt = 0;
        rst = 1;
        #1;
        n_cmp++; if (o_ready !== 1'b1 || {o_resp, o_mis, o_fault, o_mreq, o_we} !== 5'b0) begin n_fail++; $display("FAIL reset_mid_ctrl ready %b flags %b want 1 00000", o_ready, {o_resp, o_mis, o_fault, o_mreq, o_we}); end
        n_cmp++; if ({o_rdata, o_maddr, o_mwdata, o_mmask} !== '0) begin n_fail++; $display("FAIL reset_mid_data rdata %h maddr %h want 0", o_rdata, o_maddr); end
        @(negedge clk);
        rst = 0; rvalid = 1; mrdata = 64'h0000_0000_0000_00AA;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rvalid = 0;
            if (o_resp || o_mreq) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_stale_rvalid reacted %b ready %b want 0 1", seen, o_ready); end
    endtask

    initial begin
        rst = 1; sel64 = 0;
        req_valid = 0; ld = 0; st = 0; lf = '0; sf = '0; addr = '0; wdata = '0;
        gnt = 0; rvalid = 0; merr = 0; mrdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 0;
        test_directed32();
        test_xlen64();
        test_ignored_req();
        test_timeout();
        test_random();
        test_directed32();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Multi-cycle load/store unit, parametrised by XLEN (32 or 64). It replaces the single-cycle combinational memory stage with a request/grant/response bus. A pipeline-side valid/ready request is captured, alignment is checked, and one aligned bus access is issued with byte lanes and a byte mask. The returned data is extracted and sign- or zero-extended into a one-cycle response.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64; byte lanes NB = XLEN/8.
TIMEOUT, 255, maximum cycles waited in REQ or WAIT; used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-high
req_valid_i  in  1  pipeline request valid
req_ready_o  out  1  high only in IDLE
ld_i  in  1  load request
st_i  in  1  store request
ld_fun_i  in  7  one-hot load function: [0]lb [1]lh [2]lw [3]lbu [4]lhu [5]ld [6]lwu
st_fun_i  in  4  one-hot store function: [0]sb [1]sh [2]sw [3]sd
addr_i  in  XLEN  byte address
wdata_i  in  XLEN  store data, right-aligned
resp_valid_o  out  1  one-cycle completion pulse
rdata_o  out  XLEN  extended load data; 0 for stores and errors
misalign_o  out  1  valid with resp_valid_o; address misaligned
fault_o  out  1  valid with resp_valid_o; bus error, illegal function, or timeout
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write enable
mem_addr_o  out  XLEN  NB-aligned bus address
mem_wdata_o  out  XLEN  lane-positioned write data
mem_wmask_o  out  NB  byte write mask
mem_gnt_i  in  1  bus grant for the current request
mem_rvalid_i  in  1  read data valid, or write acknowledge
mem_rdata_i  in  XLEN  aligned read data
mem_err_i  in  1  bus error, qualified by mem_rvalid_i

Behaviour:
- Reset values: state IDLE; req_ready_o=1; every other output 0.
- States: IDLE, REQ, WAIT, RESP.
- Accept: in IDLE, when req_valid_i=1 and (ld_i|st_i)=1, latch addr, fun, wdata and ld/st. A request with both ld_i=0 and st_i=0 is ignored.
- Illegal requests go straight to RESP with fault_o=1 and no bus access. Illegal means: ld_i and st_i both 1; fun not one-hot; or ld/lwu/sd when XLEN=32.
- Alignment check: h requires off[0]=0, w requires off[1:0]=0, d requires off[2:0]=0, where off = addr[log2(NB)-1:0]. A misaligned request goes to RESP with misalign_o=1 and no bus access.
- Otherwise go to REQ. mem_addr_o = addr with the low log2(NB) bits cleared. mem_we_o = st.
- Store data is the size-masked wdata shifted left by off*8. The mask is (1/3/15/255 for b/h/w/d) shifted left by off.
- Load mask is all ones.
- REQ: mem_req_o=1 and all mem_* outputs stay stable until mem_gnt_i=1. On grant, move to WAIT; mem_req_o is 0 from the next cycle.
- WAIT: on mem_rvalid_i=1, go to RESP.
  - Load: rdata_o = (mem_rdata_i >> off*8), truncated to size, sign-extended for lb/lh/lw and zero-extended for lbu/lhu/lwu/ld.
  - Store: rdata_o=0.
  - If mem_err_i=1: fault_o=1 and rdata_o=0.
- mem_rvalid_i in IDLE, REQ or RESP is ignored. A response is therefore accepted no earlier than one cycle after grant.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. There is no response back-pressure. rdata_o, misalign_o and fault_o hold until the next response; the flags clear on the next accept.
- Minimum latency: accept at T, grant at T+1, rvalid at T+2, resp_valid_o at T+3. Error responses without a bus access complete at T+1.
- Reset mid-operation: immediate return to reset values. No response is produced for the aborted request, and any stale bus rvalid after reset is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8+ bit counter clears on entering REQ or WAIT and increments each cycle in those states. When it reaches TIMEOUT without grant or rvalid, drop mem_req_o and go to RESP with fault_o=1 and rdata_o=0.
- Not defined: the counter logic is absent and the unit waits indefinitely.

Test Plan:
- XLEN=32: lb at addr 0x8000_0003, bus returns 0x80FF_1234 one cycle after grant -> rdata_o=0xFFFF_FF80, resp_valid_o at T+3, fault_o=0.
- XLEN=32: sh wdata 0xDEAD_BEEF at 0x1002 -> mem_addr_o=0x1000, mem_wdata_o=0xBEEF_0000, mem_wmask_o=4'b1100, mem_we_o=1; ack -> resp with rdata_o=0.
- XLEN=32: lw at 0x1001 -> resp_valid_o at T+1, misalign_o=1, no mem_req_o. ld request -> fault_o=1.
- XLEN=64: lwu at 0x10 with grant held off 5 cycles and rdata 0xFFFF_FFFF_8765_4321 -> mem_req_o stable for 6 cycles; rdata_o=0x0000_0000_8765_4321.
- Bus error: lhu with mem_err_i=1 on rvalid -> fault_o=1, rdata_o=0. Assert rst during WAIT -> all outputs 0 and no resp_valid_o.
- LSU_TIMEOUT_EN, TIMEOUT=4, grant never asserted -> mem_req_o drops and resp_valid_o with fault_o=1 after 4 REQ cycles.
